// File: rtl/lzss_enc_pkg.sv
`default_nettype none
// ============================================================================
// Package : lzss_enc_pkg
// Purpose : Shared helpers for the LZSS encoder match unit: a constant-capable
//           clog2, a popcount used to turn a prefix mask into a length, and
//           the default symbol/window geometry of one candidate slice.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package lzss_enc_pkg;

    localparam int c_DEF_DATA_WIDTH  = 8;
    localparam int c_DEF_CODING_SIZE = 5;
    // Width of one candidate reference window inside the packed ref bus.
    localparam int c_CAND_SLICE_W    = c_DEF_DATA_WIDTH * c_DEF_CODING_SIZE;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Prefix masks are at most pCodingSize bits; callers zero-extend to 32.
    function automatic int popcount(input logic [31:0] value);
        int c;
        c = 0;
        for (int i = 0; i < 32; i++) begin
            c = c + int'(value[i]);
        end
        return c;
    endfunction

endpackage : lzss_enc_pkg
`default_nettype wire

// File: rtl/lzss_enc_match_multi_if.sv
`default_nettype none
// ============================================================================
// Interface : lzss_enc_match_multi_if
// Purpose   : Bundles the window input handshake, the candidate reference
//             bus, the flush strobe and the code output handshake of the
//             match unit.
// Modports  : slave  - match unit view (consumes windows, produces codes)
//             master - upstream/downstream view (drives windows, takes codes)
// Rev       : 1.0  initial release
// ============================================================================
interface lzss_enc_match_multi_if #(
    parameter int pDataWidth   = 8,
    parameter int pCodingSize  = 5,
    parameter int pNumCand     = 4,
    parameter int pOffsetWidth = 6,
    parameter int pLengthWidth = 3
);
    logic                                    i_clear;
    logic                                    i_valid;
    logic                                    o_ready;
    logic [pCodingSize-1:0]                  i_sym_valid;
    logic [pDataWidth*pCodingSize-1:0]       i_data;
    logic [pCodingSize-1:0]                  i_sym_last;
    logic [pNumCand*pCodingSize-1:0]         i_ref_valid;
    logic [pNumCand*pCodingSize*pDataWidth-1:0] i_ref_data;
    logic                                    o_valid;
    logic                                    i_ready;
    logic                                    o_hit;
    logic [pOffsetWidth-1:0]                 o_offset;
    logic [pLengthWidth-1:0]                 o_length;
    logic                                    o_last;

    modport slave (
        input  i_clear, i_valid, i_sym_valid, i_data, i_sym_last,
               i_ref_valid, i_ref_data, i_ready,
        output o_ready, o_valid, o_hit, o_offset, o_length, o_last
    );

    modport master (
        output i_clear, i_valid, i_sym_valid, i_data, i_sym_last,
               i_ref_valid, i_ref_data, i_ready,
        input  o_ready, o_valid, o_hit, o_offset, o_length, o_last
    );
endinterface : lzss_enc_match_multi_if
`default_nettype wire

// File: rtl/lzss_enc_match_cand.sv
`default_nettype none
// ============================================================================
// Module  : lzss_enc_match_cand
// Purpose : Combinational compare of the coding window against one candidate
//           reference window. Produces the prefix-match mask: bit j is set
//           only when symbols 0..j all match and are valid on both sides.
// Ports   : i_sym_valid - per-symbol valid of the coding window
//           i_data      - coding window, symbol 0 in LSBs
//           i_ref_valid - per-symbol valid of this candidate
//           i_ref_data  - candidate window, symbol 0 in LSBs
//           o_pm        - prefix-match mask
// Rev     : 1.0  initial release
// ============================================================================
module lzss_enc_match_cand #(
    parameter int pDataWidth  = 8,
    parameter int pCodingSize = 5
) (
    input  wire logic [pCodingSize-1:0]            i_sym_valid,
    input  wire logic [pDataWidth*pCodingSize-1:0] i_data,
    input  wire logic [pCodingSize-1:0]            i_ref_valid,
    input  wire logic [pDataWidth*pCodingSize-1:0] i_ref_data,
    output      logic [pCodingSize-1:0]            o_pm
);

    logic [pCodingSize-1:0] eq;

    always_comb begin
        eq = '0;
        for (int j = 0; j < pCodingSize; j++) begin
            eq[j] = i_sym_valid[j] & i_ref_valid[j] &
                    (i_data[j*pDataWidth +: pDataWidth] ==
                     i_ref_data[j*pDataWidth +: pDataWidth]);
        end
    end

    // Running AND: the first mismatch or invalid symbol clears every
    // higher bit, so the mask is always a contiguous run from bit 0.
    always_comb begin
        o_pm    = '0;
        o_pm[0] = eq[0];
        for (int j = 1; j < pCodingSize; j++) begin
            o_pm[j] = o_pm[j-1] & eq[j];
        end
    end

endmodule : lzss_enc_match_cand
`default_nettype wire

// File: rtl/lzss_enc_match_multi.sv
`default_nettype none
// ============================================================================
// Module  : lzss_enc_match_multi
// Purpose : LZSS encoder match unit. Compares the coding window against
//           pNumCand reference windows in parallel and emits the longest
//           match as an offset/length code with a last flag, through a
//           2-stage valid/ready pipeline (stage 1: prefix masks, stage 2:
//           max-select and code formatting).
// Ports   : clk, rst (async, active-high)
//           bus (slave) - window input handshake, reference bus, flush,
//                         and code output handshake
// Rev     : 1.0  initial release
// ============================================================================
module lzss_enc_match_multi
    import lzss_enc_pkg::*;
#(
    parameter int pDataWidth   = c_DEF_DATA_WIDTH,
    parameter int pCodingSize  = c_DEF_CODING_SIZE,
    parameter int pNumCand     = 4,
    parameter int pOffsetWidth = 6,
    parameter int pOffsetBase  = 0,
    parameter int pOffsetStep  = 1,
    parameter int pMinLength   = 2,
    parameter int pLengthWidth = 3
) (
    input wire logic              clk,
    input wire logic              rst,
    lzss_enc_match_multi_if.slave bus
);

    localparam int SLICE_W = pDataWidth * pCodingSize;
    localparam int WIN_W   = (clog2(pNumCand) > 0) ? clog2(pNumCand) : 1;

    typedef logic [pNumCand-1:0][pCodingSize-1:0] pm_arr_t;

    // ------------------------------------------------------------------
    // Per-candidate prefix masks
    // ------------------------------------------------------------------
    pm_arr_t cand_pm;

    for (genvar k = 0; k < pNumCand; k++) begin : g_cand
        lzss_enc_match_cand #(
            .pDataWidth  (pDataWidth),
            .pCodingSize (pCodingSize)
        ) u_cand (
            .i_sym_valid (bus.i_sym_valid),
            .i_data      (bus.i_data),
            .i_ref_valid (bus.i_ref_valid[k*pCodingSize +: pCodingSize]),
            .i_ref_data  (bus.i_ref_data[k*SLICE_W +: SLICE_W]),
            .o_pm        (cand_pm[k])
        );
    end

    // ------------------------------------------------------------------
    // Pipeline state
    // ------------------------------------------------------------------
    logic                    s1_valid_q, s1_valid_d;
    pm_arr_t                 s1_pm_q,    s1_pm_d;
    logic [pCodingSize-1:0]  s1_last_q,  s1_last_d;
    logic                    out_valid_q, out_valid_d;
    logic                    hit_q,      hit_d;
    logic [pOffsetWidth-1:0] offset_q,   offset_d;
    logic [pLengthWidth-1:0] length_q,   length_d;
    logic                    last_q,     last_d;

    logic s2_free;
    logic s1_free;

    // Stage 2 can take a new code when it is empty or its code leaves now;
    // stage 1 can take a window when it is empty or drains into stage 2.
    assign s2_free     = !out_valid_q || bus.i_ready;
    assign s1_free     = !s1_valid_q || s2_free;
    assign bus.o_ready = s1_free;

    // ------------------------------------------------------------------
    // Priority max-select over stage-1 masks. Strict '>' keeps the first
    // (lowest-index) candidate on equal lengths.
    // ------------------------------------------------------------------
    int               best_len;
    int               cand_len;
    logic [WIN_W-1:0] win_idx;
    int               off_full;
    logic             sel_hit;

    always_comb begin
        best_len = 0;
        cand_len = 0;
        win_idx  = '0;
        for (int k = 0; k < pNumCand; k++) begin
            cand_len = popcount(32'(s1_pm_q[k]));
            if (cand_len > best_len) begin
                best_len = cand_len;
                win_idx  = WIN_W'(k);
            end
        end
        sel_hit  = (best_len >= pMinLength);
        off_full = pOffsetBase + int'(win_idx) * pOffsetStep;
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_pm_d     = s1_pm_q;
        s1_last_d   = s1_last_q;
        out_valid_d = out_valid_q;
        hit_d       = hit_q;
        offset_d    = offset_q;
        length_d    = length_q;
        last_d      = last_q;

        if (s1_free) begin
            s1_valid_d = bus.i_valid;
            if (bus.i_valid) begin
                s1_pm_d   = cand_pm;
                s1_last_d = bus.i_sym_last;
            end
        end

        if (s2_free) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                hit_d    = sel_hit;
                offset_d = sel_hit ? pOffsetWidth'(off_full) : '0;
                length_d = sel_hit ? pLengthWidth'(best_len) : '0;
                // A miss becomes a literal of symbol 0, so only its flag matters.
                last_d   = sel_hit ? |(s1_last_q & s1_pm_q[win_idx])
                                   : s1_last_q[0];
            end
        end

        // Flush wins over any load, including a same-cycle accept.
        if (bus.i_clear) begin
            s1_valid_d  = 1'b0;
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_pm_q     <= '0;
            s1_last_q   <= '0;
            out_valid_q <= 1'b0;
            hit_q       <= 1'b0;
            offset_q    <= '0;
            length_q    <= '0;
            last_q      <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_pm_q     <= s1_pm_d;
            s1_last_q   <= s1_last_d;
            out_valid_q <= out_valid_d;
            hit_q       <= hit_d;
            offset_q    <= offset_d;
            length_q    <= length_d;
            last_q      <= last_d;
        end
    end

    assign bus.o_valid  = out_valid_q;
    assign bus.o_hit    = hit_q;
    assign bus.o_offset = offset_q;
    assign bus.o_length = length_q;
    assign bus.o_last   = last_q;

endmodule : lzss_enc_match_multi
`default_nettype wire

// File: tb/tb_lzss_enc_match_multi.sv
`default_nettype none
// ============================================================================
// Module  : tb_lzss_enc_match_multi
// Purpose : Self-checking bench for the LZSS match unit: a table of directed
//           windows with hand-computed codes streamed at full rate, then
//           stall, flush and reset sequences.
// Rev     : 1.0  initial release
// ============================================================================
module tb_lzss_enc_match_multi;
    import lzss_enc_pkg::*;

    logic clk;
    logic rst;

    lzss_enc_match_multi_if #(
        .pDataWidth(8), .pCodingSize(5), .pNumCand(4),
        .pOffsetWidth(6), .pLengthWidth(3)
    ) bus ();

    lzss_enc_match_multi #(
        .pDataWidth(8), .pCodingSize(5), .pNumCand(4), .pOffsetWidth(6),
        .pOffsetBase(0), .pOffsetStep(1), .pMinLength(2), .pLengthWidth(3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string        name;
        logic [4:0]   sv;
        logic [39:0]  data;
        logic [4:0]   sl;
        logic [19:0]  rv;
        logic [159:0] rd;
        logic         hit;
        logic [5:0]   off;
        logic [2:0]   len;
        logic         last;
    } vec_t;

    vec_t vecs[$];
    int   n_checks;
    int   n_fail;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Candidate k copies the first m[k] symbols of the window and then
    // diverges; expected code fields are supplied by hand.
    function automatic vec_t mk(input string nm, input int seed,
                                input int m0, input int m1, input int m2, input int m3,
                                input logic [4:0] sv, input logic [4:0] sl,
                                input logic [19:0] rv, input logic h,
                                input logic [5:0] o, input logic [2:0] l,
                                input logic la);
        vec_t v;
        int   m[4];
        m = '{m0, m1, m2, m3};
        v.name = nm; v.sv = sv; v.sl = sl; v.rv = rv;
        v.hit = h; v.off = o; v.len = l; v.last = la;
        v.data = '0;
        v.rd   = '0;
        for (int j = 0; j < 5; j++) v.data[j*8 +: 8] = 8'(seed * 16 + j + 1);
        for (int k = 0; k < 4; k++)
            for (int j = 0; j < 5; j++)
                v.rd[k*c_CAND_SLICE_W + j*8 +: 8] =
                    (j < m[k]) ? v.data[j*8 +: 8] : (v.data[j*8 +: 8] ^ 8'hA5);
        return v;
    endfunction

    task automatic drive(input vec_t v, input logic valid);
        bus.i_valid     = valid;
        bus.i_sym_valid = v.sv;
        bus.i_data      = v.data;
        bus.i_sym_last  = v.sl;
        bus.i_ref_valid = v.rv;
        bus.i_ref_data  = v.rd;
    endtask

    function automatic logic [10:0] outs();
        return {bus.o_hit, bus.o_offset, bus.o_length, bus.o_last};
    endfunction

    function automatic logic [10:0] expct(input vec_t v);
        return {v.hit, v.off, v.len, v.last};
    endfunction

    task automatic check_code(input string tag, input vec_t v);
        check({tag, "_hit_", v.name},  32'(bus.o_hit),    32'(v.hit));
        check({tag, "_off_", v.name},  32'(bus.o_offset), 32'(v.off));
        check({tag, "_len_", v.name},  32'(bus.o_length), 32'(v.len));
        check({tag, "_last_", v.name}, 32'(bus.o_last),   32'(v.last));
    endtask

    initial begin
        int       sent, got, cyc, n;
        logic     prev_stall;
        logic [10:0] snap;

        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1;
        bus.i_clear = 1'b0;
        bus.i_ready = 1'b1;
        bus.i_valid = 1'b0;
        bus.i_sym_valid = '0; bus.i_data = '0; bus.i_sym_last = '0;
        bus.i_ref_valid = '0; bus.i_ref_data = '0;

        vecs.push_back(mk("best5",     1, 0, 3, 5, 0, 5'h1F, 5'b00000, 20'hFFFFF, 1, 2, 5, 0));
        vecs.push_back(mk("tie3",      2, 3, 0, 0, 3, 5'h1F, 5'b00000, 20'hFFFFF, 1, 0, 3, 0));
        vecs.push_back(mk("miss1",     3, 1, 1, 0, 0, 5'h1F, 5'b00001, 20'hFFFFF, 0, 0, 0, 1));
        vecs.push_back(mk("last_in",   4, 0, 4, 0, 0, 5'h1F, 5'b00100, 20'hFFFFF, 1, 1, 4, 1));
        vecs.push_back(mk("last_out",  5, 0, 4, 0, 0, 5'h1F, 5'b10000, 20'hFFFFF, 1, 1, 4, 0));
        vecs.push_back(mk("min2",      6, 2, 0, 0, 0, 5'h1F, 5'b00000, 20'hFFFFF, 1, 0, 2, 0));
        vecs.push_back(mk("all_inv",   7, 5, 5, 5, 5, 5'h00, 5'b00001, 20'hFFFFF, 0, 0, 0, 1));
        vecs.push_back(mk("sym_brk",   8, 0, 0, 0, 5, 5'b11011, 5'b00000, 20'hFFFFF, 1, 3, 2, 0));
        vecs.push_back(mk("ref_brk",   9, 0, 0, 0, 5, 5'h1F, 5'b00000,
                          20'b11101_11111_11111_11111, 0, 0, 0, 0));
        vecs.push_back(mk("tie5",     10, 5, 5, 5, 5, 5'h1F, 5'b10000, 20'hFFFFF, 1, 0, 5, 1));
        vecs.push_back(mk("last_past",11, 0, 0, 2, 0, 5'h1F, 5'b00100, 20'hFFFFF, 1, 2, 2, 0));
        vecs.push_back(mk("mid_best", 12, 4, 5, 4, 1, 5'h1F, 5'b00000, 20'hFFFFF, 1, 1, 5, 0));
        n = vecs.size();

        // ---------------- reset state ----------------
        repeat (2) @(negedge clk);
        check("rst_o_valid", 32'(bus.o_valid), 0);
        check("rst_o_ready", 32'(bus.o_ready), 1);
        check("rst_outs",    32'(outs()),      0);
        rst = 1'b0;

        // ---------------- table, full rate ----------------
        // Vector t is driven before edge t; its code is visible after edge t+1.
        for (int t = 0; t < n + 2; t++) begin
            @(negedge clk);
            if (t < n) drive(vecs[t], 1'b1);
            else       bus.i_valid = 1'b0;
            #1;
            check("tbl_o_ready", 32'(bus.o_ready), 1);
            if (t >= 2) begin
                check({"tbl_o_valid_", vecs[t-2].name}, 32'(bus.o_valid), 1);
                check_code("tbl", vecs[t-2]);
            end else begin
                check("tbl_latency_o_valid", 32'(bus.o_valid), 0);
            end
        end
        @(negedge clk);
        check("tbl_drain_o_valid", 32'(bus.o_valid), 0);

        // ---------------- stream with 3-cycle stall ----------------
        sent = 0; got = 0; cyc = 0; prev_stall = 1'b0; snap = '0;
        while (got < 6 && cyc < 60) begin
            @(negedge clk);
            bus.i_ready = !(cyc >= 3 && cyc <= 5);
            #1;
            if (cyc >= 3 && cyc <= 5) check("stall_o_ready", 32'(bus.o_ready), 0);
            if (prev_stall) begin
                check("stall_o_valid_hold", 32'(bus.o_valid), 1);
                check("stall_outs_hold", 32'(outs()), 32'(snap));
            end
            snap       = outs();
            prev_stall = bus.o_valid && !bus.i_ready;
            if (bus.o_valid && bus.i_ready) begin
                check({"stream_code_", vecs[got].name}, 32'(outs()), 32'(expct(vecs[got])));
                got++;
            end
            if (sent < 6 && bus.o_ready) begin
                drive(vecs[sent], 1'b1);
                sent++;
            end else begin
                bus.i_valid = 1'b0;
            end
            cyc++;
        end
        check("stream_count", 32'(got), 6);
        bus.i_valid = 1'b0;
        bus.i_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            check("stream_no_dup", 32'(bus.o_valid), 0);
        end

        // ---------------- clear with 2 codes pending ----------------
        bus.i_ready = 1'b0;
        @(negedge clk); drive(vecs[0], 1'b1);
        @(negedge clk); drive(vecs[1], 1'b1);
        @(negedge clk); bus.i_valid = 1'b0; #1;
        check("clr_pending_o_valid", 32'(bus.o_valid), 1);
        check("clr_pending_o_ready", 32'(bus.o_ready), 0);
        @(negedge clk); bus.i_clear = 1'b1; drive(vecs[2], 1'b1);
        @(negedge clk); bus.i_clear = 1'b0; bus.i_valid = 1'b0; #1;
        check("clr_o_valid", 32'(bus.o_valid), 0);
        check("clr_o_ready", 32'(bus.o_ready), 1);
        // Accept coinciding with clear must vanish.
        bus.i_ready = 1'b1;
        @(negedge clk); bus.i_clear = 1'b1; drive(vecs[3], 1'b1);
        @(negedge clk); bus.i_clear = 1'b0; bus.i_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1; check("clr_accept_dropped", 32'(bus.o_valid), 0);
            @(negedge clk);
        end

        // ---------------- reset mid-stall ----------------
        bus.i_ready = 1'b0;
        @(negedge clk); drive(vecs[0], 1'b1);
        @(negedge clk); drive(vecs[1], 1'b1);
        @(negedge clk); bus.i_valid = 1'b0; #1;
        check("rststall_pending", 32'(bus.o_valid), 1);
        @(negedge clk); rst = 1'b1; #1;
        check("rststall_o_valid", 32'(bus.o_valid), 0);
        check("rststall_outs",    32'(outs()),      0);
        check("rststall_o_ready", 32'(bus.o_ready), 1);
        @(negedge clk); rst = 1'b0; bus.i_ready = 1'b1;
        drive(vecs[3], 1'b1);
        @(negedge clk); bus.i_valid = 1'b0; #1;
        check("resume_latency", 32'(bus.o_valid), 0);
        @(negedge clk); #1;
        check("resume_o_valid", 32'(bus.o_valid), 1);
        check_code("resume", vecs[3]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_lzss_enc_match_multi
`default_nettype wire
